pam_axil_reg_slave: RTL and testbench



---
 rtl/pam_axil_reg_slave_if.sv | 42 ++++
 rtl/pam_axil_reg_slave.sv | 131 +++++++++++++
 tb/tb_pam_axil_reg_slave.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pam_axil_reg_slave_if.sv
// AXI4-Lite bus bundle for the PAM searcher S00_AXI control port.
// The master modport is the VIP/bench side, the slave modport is the register block.
interface pam_axil_reg_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                        awprot;
  logic                              awvalid;
  logic                              awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb;
  logic                              wvalid;
  logic                              wready;
  logic [1:0]                        bresp;
  logic                              bvalid;
  logic                              bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                        arprot;
  logic                              arvalid;
  logic                              arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                        rresp;
  logic                              rvalid;
  logic                              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/pam_axil_reg_slave.sv
// AXI4-Lite register slave for the PAM searcher: four 32-bit control registers
// driven straight to the core, with a one-cycle update strobe per register.
// AW and W are captured independently; the register update and B response
// happen on the edge after both are held. Reads return on the AR handshake edge.
module pam_axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  pam_axil_reg_slave_if.slave           s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
  output logic [3:0]                    reg_wr_o
);
  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int NBYTES = DW / 8;
  localparam int SEL_HI = C_S_AXI_ADDR_WIDTH - 1;

  logic              aw_latched;
  logic              w_latched;
  logic [1:0]        aw_sel;
  logic [DW-1:0]     wdata_q;
  logic [NBYTES-1:0] wstrb_q;
  logic [DW-1:0]     regs [4];

  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [DW-1:0]     rdata_q;
  logic [3:0]        reg_wr_q;

  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              ar_hs;
  logic              r_hs;
  logic              commit;
  logic              aw_latched_n;
  logic              w_latched_n;
  logic              bvalid_n;
  logic              rvalid_n;
  logic [DW-1:0]     merged;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi.awprot, s_axi.arprot,
                           s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Handshakes, commit decision and next-state of the channel flags.
  always_comb begin
    aw_hs  = s_axi.awvalid && awready_q;
    w_hs   = s_axi.wvalid  && wready_q;
    b_hs   = bvalid_q && s_axi.bready;
    ar_hs  = s_axi.arvalid && arready_q;
    r_hs   = rvalid_q && s_axi.rready;
    commit = aw_latched && w_latched && !bvalid_q;

    aw_latched_n = commit ? 1'b0 : (aw_latched || aw_hs);
    w_latched_n  = commit ? 1'b0 : (w_latched  || w_hs);
    bvalid_n     = commit ? 1'b1 : (b_hs ? 1'b0 : bvalid_q);
    rvalid_n     = ar_hs  ? 1'b1 : (r_hs ? 1'b0 : rvalid_q);

    merged = regs[aw_sel];
    for (int b = 0; b < NBYTES; b++) begin
      if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Write channel: beat capture, bytewise register update, B response and strobe.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      aw_sel     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      reg_wr_q   <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      aw_latched <= aw_latched_n;
      w_latched  <= w_latched_n;
      bvalid_q   <= bvalid_n;
      awready_q  <= !aw_latched_n && !bvalid_n;
      wready_q   <= !w_latched_n  && !bvalid_n;
      if (aw_hs) aw_sel <= s_axi.awaddr[SEL_HI:2];
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (commit) regs[aw_sel] <= merged;
      reg_wr_q <= commit ? (4'b0001 << aw_sel) : 4'b0000;
    end
  end

  // Read channel: sample the register file on the AR handshake, hold until R completes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q  <= rvalid_n;
      arready_q <= !rvalid_n;
      if (ar_hs)     rdata_q <= regs[s_axi.araddr[SEL_HI:2]];
      else if (r_hs) rdata_q <= '0;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;

  assign reg0_o   = regs[0];
  assign reg1_o   = regs[1];
  assign reg2_o   = regs[2];
  assign reg3_o   = regs[3];
  assign reg_wr_o = reg_wr_q;
endmodule

// File: tb/tb_pam_axil_reg_slave.sv
// Self-checking bench for pam_axil_reg_slave: directed scenarios plus randomized
// AXI4-Lite traffic, checked against a word-array model of the four registers.
module tb_pam_axil_reg_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  reg_wr;

  int          errorCount = 0;
  int          checkCount = 0;
  logic [31:0] model [4];

  pam_axil_reg_slave_if bus ();

  pam_axil_reg_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus.slave),
    .reg0_o        (reg0),
    .reg1_o        (reg1),
    .reg2_o        (reg2),
    .reg3_o        (reg3),
    .reg_wr_o      (reg_wr)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case a scenario wedges outside its own cycle bounds.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] regOut(input int k);
    case (k)
      0: return reg0;
      1: return reg1;
      2: return reg2;
      default: return reg3;
    endcase
  endfunction

  task automatic idleBus();
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  // Assert reset at a falling edge, check the asynchronous clear, release, check readies.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    idleBus();
    #1;
    checkOutput("rst_awready", 32'(bus.awready), 0);
    checkOutput("rst_wready", 32'(bus.wready), 0);
    checkOutput("rst_arready", 32'(bus.arready), 0);
    checkOutput("rst_bvalid", 32'(bus.bvalid), 0);
    checkOutput("rst_rvalid", 32'(bus.rvalid), 0);
    checkOutput("rst_rdata", bus.rdata, 0);
    checkOutput("rst_resp", 32'({bus.bresp, bus.rresp}), 0);
    checkOutput("rst_reg_wr", 32'(reg_wr), 0);
    for (int k = 0; k < 4; k++) checkOutput("rst_reg", regOut(k), 0);
    for (int k = 0; k < 4; k++) model[k] = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_awready", 32'(bus.awready), 1);
    checkOutput("rel_wready", 32'(bus.wready), 1);
    checkOutput("rel_arready", 32'(bus.arready), 1);
  endtask

  // Drive an optional write and an optional read concurrently, with per-channel
  // valid delays and ready backpressure, checking timing, values and stability.
  task automatic applyStimulus(input bit doWr, input bit doRd,
                               input logic [3:0] wAddr, input logic [31:0] wData, input logic [3:0] wStrb,
                               input int awDly, input int wDly, input int bDly,
                               input logic [3:0] rAddr, input int arDly, input int rDly);
    bit awDone = !doWr;
    bit wDone = !doWr;
    bit bDone = !doWr;
    bit arDone = !doRd;
    bit rDone = !doRd;
    bit finished = 1'b0;
    int awHs = -1, wHs = -1, bSeen = -1, bEnd = -1;
    int arHs = -1, rSeen = -1, rEnd = -1;
    int sel = int'(wAddr[3:2]);
    logic [31:0] expR = 32'h0;
    for (int c = 0; c < 80 && !finished; c++) begin
      @(negedge clk);
      if (doWr) begin
        if (awDone) bus.awvalid = 1'b0;
        else if (c >= awDly) begin
          bus.awvalid = 1'b1; bus.awaddr = wAddr; bus.awprot = 3'($urandom);
        end
        if (!awDone && bus.awvalid && bus.awready) begin awDone = 1'b1; awHs = c; end
        if (wDone) bus.wvalid = 1'b0;
        else if (c >= wDly) begin
          bus.wvalid = 1'b1; bus.wdata = wData; bus.wstrb = wStrb;
        end
        if (!wDone && bus.wvalid && bus.wready) begin wDone = 1'b1; wHs = c; end
        if (!bDone) begin
          if (bSeen < 0 && bus.bvalid) begin
            bSeen = c;
            checkOutput("b_latency", c, (awHs < 0 || wHs < 0) ? 32'hFFFF_FFFF
                                          : 32'(((awHs > wHs) ? awHs : wHs) + 2));
            for (int b = 0; b < 4; b++)
              if (wStrb[b]) model[sel][8*b +: 8] = wData[8*b +: 8];
            checkOutput("reg_wr_pulse", 32'(reg_wr), 32'(4'b0001 << sel));
            for (int k = 0; k < 4; k++) checkOutput("reg_out", regOut(k), model[k]);
          end
          if (bSeen >= 0) begin
            checkOutput("bvalid_hold", 32'(bus.bvalid), 1);
            checkOutput("bresp", 32'(bus.bresp), 0);
            checkOutput("awready_low", 32'(bus.awready), 0);
            checkOutput("wready_low", 32'(bus.wready), 0);
            if (c - bSeen >= bDly) begin bus.bready = 1'b1; bDone = 1'b1; bEnd = c; end
          end
        end
        if (bSeen >= 0 && c == bSeen + 1) checkOutput("reg_wr_clear", 32'(reg_wr), 0);
        if (bEnd >= 0 && c == bEnd + 1) begin
          bus.bready = 1'b0;
          checkOutput("bvalid_clear", 32'(bus.bvalid), 0);
          checkOutput("awready_back", 32'(bus.awready), 1);
          checkOutput("wready_back", 32'(bus.wready), 1);
        end
      end
      if (doRd) begin
        if (arDone) bus.arvalid = 1'b0;
        else if (c >= arDly) begin
          bus.arvalid = 1'b1; bus.araddr = rAddr; bus.arprot = 3'($urandom);
        end
        if (!arDone && bus.arvalid && bus.arready) begin
          arDone = 1'b1; arHs = c; expR = model[rAddr[3:2]];
        end
        if (!rDone) begin
          if (rSeen < 0 && bus.rvalid) begin
            rSeen = c;
            checkOutput("r_latency", c, (arHs < 0) ? 32'hFFFF_FFFF : 32'(arHs + 1));
          end
          if (rSeen >= 0) begin
            checkOutput("rvalid_hold", 32'(bus.rvalid), 1);
            checkOutput("rdata", bus.rdata, expR);
            checkOutput("rresp", 32'(bus.rresp), 0);
            checkOutput("arready_low", 32'(bus.arready), 0);
            if (c - rSeen >= rDly) begin bus.rready = 1'b1; rDone = 1'b1; rEnd = c; end
          end
        end
        if (rEnd >= 0 && c == rEnd + 1) begin
          bus.rready = 1'b0;
          checkOutput("rvalid_clear", 32'(bus.rvalid), 0);
          checkOutput("rdata_clear", bus.rdata, 0);
          checkOutput("arready_back", 32'(bus.arready), 1);
        end
      end
      finished = (!doWr || (bEnd >= 0 && c >= bEnd + 1)) && (!doRd || (rEnd >= 0 && c >= rEnd + 1));
    end
    checkOutput("transfer_done", 32'(finished), 1);
    idleBus();
  endtask

  task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awDly, input int wDly, input int bDly);
    applyStimulus(1'b1, 1'b0, addr, data, strb, awDly, wDly, bDly, 4'h0, 0, 0);
  endtask

  task automatic axiRead(input logic [3:0] addr, input int arDly, input int rDly);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, 4'h0, 0, 0, 0, addr, arDly, rDly);
  endtask

  // Start a write or read, hit reset while its response is pending, and make
  // sure nothing from the dropped transfer leaks out afterwards.
  task automatic resetMidTransfer(input bit isRead);
    bit seen = 1'b0;
    @(negedge clk);
    if (isRead) begin
      bus.arvalid = 1'b1; bus.araddr = 4'($urandom); bus.rready = 1'b0;
    end else begin
      bus.awvalid = 1'b1; bus.awaddr = 4'($urandom);
      bus.wvalid = 1'b1; bus.wdata = $urandom | 32'h1; bus.wstrb = 4'hF; bus.bready = 1'b0;
    end
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = isRead ? bus.rvalid : bus.bvalid;
    end
    checkOutput(isRead ? "rvalid_before_reset" : "bvalid_before_reset", 32'(seen), 1);
    doReset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("stray_b", 32'(bus.bvalid), 0);
      checkOutput("stray_r", 32'(bus.rvalid), 0);
    end
  endtask

  initial begin
    bit doWr, doRd;
    int kind;
    idleBus();
    for (int k = 0; k < 4; k++) model[k] = 32'h0;
    doReset();

    $display("[TB] sequential writes and reads");
    for (int k = 0; k < 4; k++) axiWrite(4'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0);
    for (int k = 0; k < 4; k++) axiRead(4'(4 * k), 0, 0);

    $display("[TB] AW/W ordering");
    axiWrite(4'h8, $urandom, 4'hF, 0, 3, 0);
    axiWrite(4'h8, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    checkOutput("reg2_deadbeef", reg2, 32'hDEADBEEF);
    axiRead(4'h8, 0, 0);

    $display("[TB] partial strobes");
    axiWrite(4'h4, 32'h11223344, 4'hF, 0, 0, 0);
    axiWrite(4'h4, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    checkOutput("strobe_merge", reg1, 32'h11BB33DD);
    axiRead(4'h4, 0, 0);
    axiWrite(4'h4, 32'h55667788, 4'b0000, 0, 0, 0);
    checkOutput("strobe_none", reg1, 32'h11BB33DD);
    axiRead(4'h4, 0, 0);

    $display("[TB] backpressure");
    axiWrite(4'h0, 32'hCAFE0001, 4'hF, 0, 0, 5);
    axiRead(4'h0, 0, 5);

    $display("[TB] concurrent read and write");
    axiWrite(4'h4, 32'h5, 4'hF, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 4'h4, 32'h9, 4'hF, 0, 0, 0, 4'h4, 0, 0);
    checkOutput("reg1_after_concurrent", reg1, 32'h9);
    axiWrite(4'hC, 32'h0BADF00D, 4'hF, 0, 0, 0);
    axiRead(4'hC, 0, 0);
    axiRead(4'hF, 1, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      doWr = (kind != 1);
      doRd = (kind != 0);
      applyStimulus(doWr, doRd, 4'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] reset during pending responses");
    axiWrite(4'h0, 32'h12345678, 4'hF, 0, 0, 0);
    resetMidTransfer(1'b0);
    axiWrite(4'h8, 32'h87654321, 4'hF, 0, 0, 0);
    resetMidTransfer(1'b1);
    for (int k = 0; k < 4; k++) axiRead(4'(4 * k), 0, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule
